// File: rtl/profile_accumulator_pkg.sv
// Shared types and defaults for the pulse-profile accumulator.
package profile_accumulator_pkg;

  // Top-level operating modes of the accumulator.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    ACCUM = 2'd1,
    DUMP  = 2'd2
  } state_t;

  localparam int DEF_BIN_W = 10;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_WGT_W = 16;

  localparam logic [DEF_ACC_W-1:0] ACC_MAX = {DEF_ACC_W{1'b1}};

  // Increment a 16-bit counter, holding at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/profile_accumulator_ram.sv
// Simple dual-port synchronous RAM holding the per-bin accumulators.
// One read and one write port, one-cycle read latency, and a read that
// collides with a write to the same address returns the old contents.
module profile_ram
  import profile_accumulator_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = DEF_BIN_W,
  parameter int DW    = DEF_ACC_W
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; old data wins on a same-address collision.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/profile_accumulator.sv
// Integrated pulse-profile builder: adds each pulse weight into its phase bin
// through a two-stage read-modify-write pipeline (with same-bin forwarding),
// and streams the whole profile out over valid/ready when asked.
module profile_accumulator
  import profile_accumulator_pkg::*;
#(
  parameter int NUM_BINS      = 1024,
  parameter int BIN_W         = DEF_BIN_W,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int WGT_W         = DEF_WGT_W,
  parameter bit CLEAR_ON_DUMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bin_valid,
  input  logic [BIN_W-1:0] bin_index,
  input  logic [WGT_W-1:0] bin_weight,
  output logic             in_ready,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BIN_W-1:0] out_index,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             overflow,
  output logic [15:0]      drop_count
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [ACC_W-1:0] SAT_VAL  = {ACC_W{1'b1}};

  state_t state, state_next;

  logic [BIN_W-1:0] clr_ptr;

  // S1 stage of the accumulate pipeline
  logic             s1_valid;
  logic [BIN_W-1:0] s1_index;
  logic [WGT_W-1:0] s1_weight;
  logic             s1_fwd;
  logic [ACC_W-1:0] s1_fwd_data;
  logic [ACC_W-1:0] s1_base;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] s1_sum;
  logic             s1_sat;

  // dump read-ahead: f_idx was read last cycle, ptr is the next to read
  logic             f_valid;
  logic [BIN_W-1:0] f_idx;
  logic [BIN_W-1:0] ptr;
  logic             ptr_done;

  logic accept, dump_accept, out_fire, dump_adv, dump_issue, dump_end;

  logic [BIN_W-1:0] rd_addr, wr_addr;
  logic [ACC_W-1:0] rd_data, wr_data;
  logic             wr_en;

  profile_ram #(
    .DEPTH (NUM_BINS),
    .AW    (BIN_W),
    .DW    (ACC_W)
  ) u_ram (
    .clk     (clk),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  assign out_fire   = out_valid && out_ready;
  assign dump_adv   = !out_valid || out_ready;
  assign dump_issue = dump_adv && !ptr_done;
  assign dump_end   = (state == DUMP) && out_fire && out_last;

  // S1 adder: take the forwarded result when the previous event hit the same bin.
  always_comb begin
    s1_base  = s1_fwd ? s1_fwd_data : rd_data;
    sum_wide = {1'b0, s1_base} + (ACC_W + 1)'(s1_weight);
    s1_sat   = sum_wide[ACC_W];
    if (s1_sat) begin
      s1_sum = SAT_VAL;
    end else begin
      s1_sum = sum_wide[ACC_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: clear sweep, accumulate, drain then dump, back to accumulate.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR: begin
        if (clr_ptr == LAST_BIN) begin
          state_next = ACCUM;
        end else begin
          state_next = CLEAR;
        end
      end
      ACCUM: begin
        if (dump_busy && !s1_valid) begin
          state_next = DUMP;
        end else begin
          state_next = ACCUM;
        end
      end
      DUMP: begin
        if (out_fire && out_last) begin
          state_next = ACCUM;
        end else begin
          state_next = DUMP;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // Per-state outputs: input handshake and RAM port steering.
  always_comb begin
    in_ready    = 1'b0;
    dump_accept = 1'b0;
    accept      = 1'b0;
    rd_addr     = bin_index;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_ptr;
      end
      ACCUM: begin
        in_ready    = !dump_busy && !dump_start;
        dump_accept = !dump_busy && dump_start;
        accept      = bin_valid && !dump_busy && !dump_start;
        wr_en       = s1_valid;
        wr_addr     = s1_index;
        wr_data     = s1_sum;
      end
      DUMP: begin
        // while stalled, re-read the fetched bin so rd_data stays put
        rd_addr = dump_issue ? ptr : f_idx;
        wr_en   = CLEAR_ON_DUMP && out_fire;
        wr_addr = out_index;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Clear sweep pointer, one bin per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + BIN_W'(1);
    end else begin
      clr_ptr <= '0;
    end
  end

  // S0 -> S1 pipeline register, capturing the forward decision at issue time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_index    <= '0;
      s1_weight   <= '0;
      s1_fwd      <= 1'b0;
      s1_fwd_data <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_index    <= bin_index;
        s1_weight   <= bin_weight;
        s1_fwd      <= s1_valid && (s1_index == bin_index);
        s1_fwd_data <= s1_sum;
      end
    end
  end

  // Sticky saturation flag, released when a dump completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (dump_end) begin
      overflow <= 1'b0;
    end else if (s1_valid && s1_sat && (state == ACCUM)) begin
      overflow <= 1'b1;
    end
  end

  // Saturating count of offered events that could not be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= 16'd0;
    end else if (bin_valid && !in_ready) begin
      drop_count <= sat_inc16(drop_count);
    end
  end

  // Dump busy: from the accepted request until the final beat transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_busy <= 1'b0;
    end else if (dump_accept) begin
      dump_busy <= 1'b1;
    end else if (dump_end) begin
      dump_busy <= 1'b0;
    end
  end

  // Dump read-ahead: issue the next bin read whenever the output can advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_valid  <= 1'b0;
      f_idx    <= '0;
      ptr      <= '0;
      ptr_done <= 1'b0;
    end else if (state != DUMP) begin
      f_valid  <= 1'b0;
      f_idx    <= '0;
      ptr      <= '0;
      ptr_done <= 1'b0;
    end else if (dump_adv) begin
      f_valid <= !ptr_done;
      if (!ptr_done) begin
        f_idx    <= ptr;
        ptr      <= ptr + BIN_W'(1);
        ptr_done <= (ptr == LAST_BIN);
      end
    end
  end

  // Output beat register, held stable while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (state != DUMP) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (dump_adv) begin
      out_valid <= f_valid;
      out_last  <= f_valid && (f_idx == LAST_BIN);
      if (f_valid) begin
        out_index <= f_idx;
        out_data  <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_profile_accumulator.sv
// Randomised self-checking bench for profile_accumulator with a bin-array model.
module tb_profile_accumulator;

  localparam int NB = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bin_valid = 1'b0;
  logic [9:0]  bin_index = 10'd0;
  logic [15:0] bin_weight = 16'd0;
  logic        in_ready;
  logic        dump_start = 1'b0;
  logic        dump_busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_index;
  logic [31:0] out_data;
  logic        out_last;
  logic        overflow;
  logic [15:0] drop_count;

  profile_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .bin_valid  (bin_valid),
    .bin_index  (bin_index),
    .bin_weight (bin_weight),
    .in_ready   (in_ready),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_data   (out_data),
    .out_last   (out_last),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model: bin contents, remaining clear cycles, dump progress, flags
  longint unsigned m_bins [NB];
  logic [31:0]     cap [NB];
  int              clr_left = NB;
  bit              m_busy = 1'b0;
  int              m_next_out = 0;
  bit              m_ovf = 1'b0;
  bit              m_ovf_pend = 1'b0;
  int              m_drops = 0;
  int              last_idx_seen = 0;
  bit              prev_stall = 1'b0;
  logic [9:0]      prev_idx;
  logic [31:0]     prev_data;
  bit              exp_ir;
  bit              sat_now;
  longint unsigned s;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic int nonzero();
    int c = 0;
    for (int i = 0; i < NB; i++) begin
      if (cap[i] != 32'd0) c++;
    end
    return c;
  endfunction

  // Compare process: check outputs against the model, then advance the model
  // by what the coming rising edge must do.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_flags", 64'({in_ready, dump_busy, out_valid, out_last, overflow}), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      chk("rst_out", 64'({out_index, out_data}), 64'd0);
      for (int i = 0; i < NB; i++) m_bins[i] = 0;
      clr_left = NB; m_busy = 1'b0; m_next_out = 0; m_ovf = 1'b0;
      m_ovf_pend = 1'b0; m_drops = 0; prev_stall = 1'b0;
    end else begin
      exp_ir = (clr_left == 0) && !m_busy && !dump_start;
      chk("in_ready", 64'(in_ready), 64'(exp_ir));
      chk("dump_busy", 64'(dump_busy), 64'(m_busy));
      chk("drop_count", 64'(drop_count), 64'(m_drops));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (prev_stall) begin
        chk("stall_hold", 64'({out_valid, out_index, out_data}), 64'({1'b1, prev_idx, prev_data}));
      end
      if (out_valid) begin
        chk("beat_index", 64'(out_index), 64'(m_next_out));
        chk("beat_data", 64'(out_data), m_bins[out_index]);
        chk("beat_last", 64'(out_last), 64'(out_index == 10'd1023));
      end
      // predict the coming edge
      sat_now = 1'b0;
      if (bin_valid && !exp_ir && m_drops < 65535) m_drops++;
      if (bin_valid && exp_ir) begin
        s = m_bins[bin_index] + 64'(bin_weight);
        if (s > 64'hFFFF_FFFF) begin
          s = 64'hFFFF_FFFF;
          sat_now = 1'b1;
        end
        m_bins[bin_index] = s;
      end
      m_ovf = m_ovf | m_ovf_pend;
      m_ovf_pend = sat_now;
      if (dump_start && clr_left == 0 && !m_busy) begin
        m_busy = 1'b1;
        m_next_out = 0;
      end
      if (out_valid && out_ready) begin
        cap[out_index] = out_data;
        m_bins[out_index] = 0;
        m_next_out++;
        if (out_last) last_idx_seen = int'(out_index);
        if (out_index == 10'd1023) begin
          m_busy = 1'b0;
          m_ovf = 1'b0;
          m_next_out = 0;
        end
      end
      if (clr_left > 0) clr_left--;
      prev_stall = out_valid && !out_ready;
      prev_idx = out_index;
      prev_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; bin_valid = 1'b0; dump_start = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_accum(output int n);
    n = 0;
    while (!in_ready && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic run_dump(input int mode, output int cyc);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    chk("busy_rise", 64'(dump_busy), 64'd1);
    cyc = 0;
    while (dump_busy && cyc < 6000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("dump_done", 64'(dump_busy), 64'd0);
  endtask

  task automatic send(input int idx, input int w);
    bin_valid = 1'b1;
    bin_index = 10'(idx);
    bin_weight = 16'(w);
    tick();
    bin_valid = 1'b0;
  endtask

  initial begin
    #(1_500_000);
    $display("FAIL watchdog no_finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int cyc;
    int k;

    // reset, clear sweep length, empty dump
    apply_reset();
    wait_accum(n);
    chk("clear_len", 64'(n), 64'd1024);
    run_dump(0, cyc);
    chk("empty_zero", 64'(nonzero()), 64'd0);
    chk("last_idx", 64'(last_idx_seen), 64'd1023);
    chk("dump_rate", 64'(cyc <= 1032), 64'd1);

    // back-to-back same-bin events
    bin_valid = 1'b1; bin_index = 10'd5; bin_weight = 16'd1;
    repeat (3) tick();
    bin_index = 10'd7; bin_weight = 16'd10;
    tick();
    bin_valid = 1'b0;
    tick();
    run_dump(0, cyc);
    chk("fwd_bin5", 64'(cap[5]), 64'd3);
    chk("fwd_bin7", 64'(cap[7]), 64'd10);
    chk("fwd_others", 64'(nonzero()), 64'd2);

    // randomised traffic with colliding bins and an occasional dump request
    for (int i = 0; i < 400; i++) begin
      bin_valid = ($urandom_range(0, 9) < 7);
      bin_index = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 7));
      bin_weight = 16'($urandom);
      dump_start = ($urandom_range(0, 299) == 0);
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bin_valid = 1'b0; dump_start = 1'b0;
    k = 0;
    while (dump_busy && k < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    out_ready = 1'b0;
    chk("rand_idle", 64'(dump_busy), 64'd0);
    tick();
    run_dump(2, cyc);

    // saturation of bin 3
    bin_valid = 1'b1; bin_index = 10'd3; bin_weight = 16'hFFFF;
    for (int i = 0; i < 65536; i++) tick();
    bin_weight = 16'hFFF0;
    tick();
    bin_valid = 1'b0;
    repeat (3) tick();
    chk("pre_sat_ovf", 64'(overflow), 64'd0);
    send(3, 32'h20);
    repeat (3) tick();
    chk("sat_ovf", 64'(overflow), 64'd1);
    run_dump(1, cyc);
    chk("sat_bin3", 64'(cap[3]), 64'hFFFF_FFFF);
    chk("sat_cleared", 64'(overflow), 64'd0);
    run_dump(0, cyc);
    chk("redump_zero", 64'(nonzero()), 64'd0);

    // drops during the clear sweep; dump request ignored there
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      bin_valid = 1'b1;
      bin_index = 10'($urandom_range(0, 1023));
      bin_weight = 16'($urandom);
      dump_start = (i == 5);
      tick();
    end
    bin_valid = 1'b0; dump_start = 1'b0;
    tick();
    chk("drops_20", 64'(drop_count), 64'd20);
    chk("clear_no_busy", 64'(dump_busy), 64'd0);
    wait_accum(n);
    chk("accum_after_drop", 64'(in_ready), 64'd1);

    // asynchronous reset in the middle of a dump
    send(0, 7); send(500, 9); send(1023, 4);
    tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (!(out_valid && out_index == 10'd500) && k < 3000) begin
      tick();
      k++;
    end
    chk("reach_500", 64'(out_data), 64'd9);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(dump_busy), 64'd0);
    chk("arst_index", 64'(out_index), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    wait_accum(n);
    chk("clear_len_2", 64'(n), 64'd1024);
    run_dump(0, cyc);
    chk("post_arst_zero", 64'(nonzero()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/profile_accumulator.md
Name: profile_accumulator

Overview:
Downstream stage of the phase/bin calculator. Folds each detected pulse into a per-bin accumulator array to build the integrated pulse profile. Adds a per-pulse weight to the addressed bin through a 2-stage read-modify-write pipeline with same-bin forwarding. Streams the completed profile out over a valid/ready interface on request, optionally clearing each bin as it is read.

Parameters:
NUM_BINS, 1024, number of phase bins (power of two)
BIN_W, 10, bin index width (log2 NUM_BINS)
ACC_W, 32, accumulator width per bin
WGT_W, 16, per-pulse weight width
CLEAR_ON_DUMP, 1, 1 = zero each bin after it is accepted on the output

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
bin_valid  in  1  pulse event with a valid bin index
bin_index  in  BIN_W  target bin
bin_weight  in  WGT_W  unsigned amount added to the bin
in_ready  out  1  high only in ACCUM state and not stalled for a dump
dump_start  in  1  single-cycle request to stream the profile out
dump_busy  out  1  high from dump acceptance until the last beat is accepted
out_valid  out  1  output beat valid
out_ready  in  1  consumer ready
out_index  out  BIN_W  bin number of the current beat
out_data  out  ACC_W  accumulated value
out_last  out  1  high on bin NUM_BINS-1
overflow  out  1  sticky; set when any add saturates; cleared by reset or at dump completion
drop_count  out  16  saturating count of cycles with bin_valid && !in_ready

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0. State goes to CLEAR.
- State CLEAR: writes 0 to bins 0..NUM_BINS-1, one bin per cycle, over NUM_BINS cycles; then moves to ACCUM. in_ready = 0.
- State ACCUM, accept: an event is accepted when bin_valid && in_ready.
- ACCUM stage S0: issue the synchronous read of bin_index; register index and weight.
- ACCUM stage S1: sum = rd_data + weight, saturated at 2^ACC_W-1; write back. Saturation sets overflow.
- Write latency: each accepted event is committed 2 cycles after acceptance. Throughput is one event per cycle.
- Forwarding: when an S0 index equals the index being written in S1 on the same cycle, S1's result is used in place of the RAM read data. Back-to-back events to the same bin must never lose an increment.
- Dump acceptance: dump_start is honoured only in ACCUM; it is ignored in CLEAR and DUMP. On acceptance, in_ready drops the same cycle and dump_busy rises the next cycle.
- Transition to DUMP: DUMP is entered once the S1 write has committed (pipeline drained).
- State DUMP: streams bins 0..NUM_BINS-1 in order. The first out_valid appears within 2 cycles of entering DUMP.
- DUMP handshake: out_valid/out_index/out_data stay stable while out_valid && !out_ready. A beat transfers on out_valid && out_ready. Full rate (one beat per cycle) when out_ready is held high; a prefetch register hides the read latency.
- DUMP clear: if CLEAR_ON_DUMP = 1, the accepted bin is written to 0 in the transfer cycle.
- End of dump: out_last is high with index NUM_BINS-1. After that beat transfers, dump_busy and overflow clear and the state returns to ACCUM.
- Drops: any bin_valid while in_ready = 0 is discarded and increments drop_count, which saturates at 0xFFFF. It is never cleared except by reset.
- Mid-operation reset: an asynchronous rst in any state aborts immediately. Outputs go to 0, the state goes to CLEAR, and in-flight events are lost.
- Bin range: bin_index is always in range because NUM_BINS = 2^BIN_W; no range check is performed.

Decomposition:
- Shared package: state enum {CLEAR, ACCUM, DUMP}; default widths BIN_W/ACC_W/WGT_W; constant ACC_MAX = all-ones of ACC_W.
- One sub-module: profile_ram, a simple dual-port synchronous RAM (1 read port, 1 write port, 1-cycle read latency, read-old-data on a same-address collision). Forwarding is handled in the parent.

Test Plan:
- Reset release -> in_ready stays 0 for exactly 1024 cycles, then goes to 1. An immediate dump returns all 1024 bins = 0, with out_last on index 1023.
- Events (5,1), (5,1), (5,1) on consecutive cycles, then (7,10) -> dump gives bin5 = 3, bin7 = 10, all other bins 0 (forwarding check).
- Preload bin 3 near full (0xFFFFFFF0 via repeated weights), then add weight 0x20 -> bin3 = 0xFFFFFFFF and overflow = 1. overflow clears after the dump completes.
- dump_start with out_ready toggling 1,0,0,1 -> no duplicated or skipped indices and data stable while stalled. With CLEAR_ON_DUMP = 1, a second dump returns all zeros.
- bin_valid held high for 20 cycles during CLEAR -> drop_count = 20 and no bins are modified.
- Assert rst mid-dump at index 500 -> outputs 0 immediately and the block re-enters CLEAR. The next dump shows all bins = 0.
